// File: rtl/shared_timer_arbiter.sv
//-----------------------------------------------------------------------------
// shared_timer_arbiter
//
// Purpose:
//   Shares one CW-bit step counter among NREQ requesters. Each requester
//   raises req[i] together with a length len[i]. The arbiter picks one
//   requester round-robin, runs the counter for max(len,1) cycles, and then
//   pulses done[i] for one cycle. Only one delay runs at a time.
//
// Ports:
//   clk    in   1         clock, rising edge
//   rst_n  in   1         asynchronous active-low reset
//   req    in   NREQ      level request per requester, held until its done
//   len    in   NREQ*CW   requested length, requester i uses [i*CW +: CW]
//   grant  out  NREQ      one-hot owner of the counter (registered)
//   busy   out  1         high whenever the arbiter is not idle
//   done   out  NREQ      one-cycle completion pulse to the owner (registered)
//   count  out  CW        current step count (registered)
//-----------------------------------------------------------------------------
module shared_timer_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic [NREQ-1:0]    done,
    output logic [CW-1:0]      count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic [CW-1:0]     r_lq;
    logic [CW-1:0]     r_count;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_done;

    logic              w_any;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_idx;
    logic [NREQ-1:0]   w_onehot;
    logic [CW-1:0]     w_len;
    logic [CW-1:0]     w_last;

    // Final count value for a latched length: a length of zero still runs
    // for one cycle, so the last step is 0 for both len=0 and len=1.
    function automatic logic [CW-1:0] last_step(input logic [CW-1:0] lq);
        if (lq == '0) begin
            return '0;
        end
        return lq - CW'(1);
    endfunction

    // Round-robin search starting just after the last winner. The loop runs
    // from the farthest candidate towards the nearest one so that the
    // nearest asserted request is the one left in w_win.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = PW'((int'(r_ptr) + k) % NREQ);
            if (req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_onehot = NREQ'(1) << w_win;
    assign w_len    = len[int'(w_win)*CW +: CW];
    assign w_last   = last_step(r_lq);

    // Sequencer: IDLE -> RUN (T cycles) -> DONE (1 cycle) -> IDLE.
    // req and len are only looked at in IDLE; a running delay cannot be
    // cancelled by the requester, only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= PW'(NREQ - 1);
            r_lq    <= '0;
            r_count <= '0;
            r_grant <= '0;
            r_done  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_count <= '0;
                    r_done  <= '0;
                    if (w_any) begin
                        r_state <= S_RUN;
                        r_grant <= w_onehot;
                        r_ptr   <= w_win;
                        r_lq    <= w_len;
                    end else begin
                        r_grant <= '0;
                    end
                end
                S_RUN: begin
                    if (r_count == w_last) begin
                        // Count holds at T-1 through the DONE cycle.
                        r_state <= S_DONE;
                        r_done  <= r_grant;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_done  <= '0;
                    r_count <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_done  <= '0;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign count = r_count;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_shared_timer_arbiter.sv
module tb_shared_timer_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*CW-1:0] len = '0;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [NREQ-1:0]    done;
    logic [CW-1:0]      count;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    shared_timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .len   (len),
        .grant (grant),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: who owns the timer, how many cycles since the grant,
    // and the delay length. Outputs follow directly from those numbers.
    int m_owner = -1;
    int m_age   = 0;
    int m_T     = 1;
    int m_ptr   = NREQ - 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_age   = 0;
            m_T     = 1;
            m_ptr   = NREQ - 1;
        end else if (m_owner < 0) begin
            int f;
            f = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int w;
                w = (m_ptr + k) % NREQ;
                if (f < 0 && req[w]) f = w;
            end
            if (f >= 0) begin
                int l;
                l       = int'(len[f*CW +: CW]);
                m_owner = f;
                m_ptr   = f;
                m_age   = 0;
                m_T     = (l == 0) ? 1 : l;
            end
        end else if (m_age == m_T) begin
            m_owner = -1;
            m_age   = 0;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int eg, ed, eb, ec;
            eg = (m_owner >= 0) ? (1 << m_owner) : 0;
            ed = (m_owner >= 0 && m_age == m_T) ? (1 << m_owner) : 0;
            eb = (m_owner >= 0) ? 1 : 0;
            ec = (m_owner < 0) ? 0 : ((m_age < m_T) ? m_age : m_T - 1);
            chk("grant", 32'(grant), 32'(eg));
            chk("done",  32'(done),  32'(ed));
            chk("busy",  32'(busy),  32'(eb));
            chk("count", 32'(count), 32'(ec));
        end
    end

    // One request in isolation; checks latency, grant length and final count.
    task automatic run_single(input int idx, input int l, input int exp_gcyc,
                              input int exp_fin, input bit disturb);
        int gcyc;
        int fin;
        bit seen;
        gcyc = 0;
        fin  = -1;
        seen = 1'b0;
        @(negedge clk);
        req      = '0;
        req[idx] = 1'b1;
        len[idx*CW +: CW] = CW'(l);
        @(negedge clk);
        chk("latency", 32'(grant), 32'(1 << idx));
        for (int c = 0; c < 40 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            if (grant[idx]) gcyc++;
            if (done != '0) begin
                seen     = 1'b1;
                fin      = int'(count);
                req[idx] = 1'b0;
            end
            if (disturb && c == 3) begin
                len[idx*CW +: CW] = CW'(3);
                req[3] = 1'b1;
            end
            if (disturb && c == 5) req[3] = 1'b0;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("grant_cycles", 32'(gcyc), 32'(exp_gcyc));
        chk("final_count", 32'(fin), 32'(exp_fin));
        @(negedge clk);
        chk("idle_after", 32'(grant), 32'd0);
    endtask

    initial begin
        int ord[$];
        logic [NREQ-1:0] prev;
        bit hit;

        // Reset then idle
        rst_n = 1'b0;
        req   = '0;
        len   = '0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_grant", 32'(grant), 32'd0);
            chk("idle_busy",  32'(busy),  32'd0);
        end

        // Round-robin with everyone requesting, all lengths 2
        @(negedge clk);
        len  = {NREQ{CW'(2)}};
        req  = '1;
        prev = '0;
        for (int c = 0; c < 60 && ord.size() < 5; c++) begin
            @(negedge clk);
            if (grant != '0 && grant != prev) begin
                for (int i = 0; i < NREQ; i++) if (grant[i]) ord.push_back(i);
            end
            prev = grant;
        end
        chk("rr_grants", 32'(ord.size()), 32'd5);
        for (int k = 0; k < ord.size(); k++) chk("rr_order", 32'(ord[k]), 32'(k % NREQ));
        req = '0;
        repeat (8) @(negedge clk);

        // Single request, zero length, and max length with disturbance
        run_single(2, 5, 6, 4, 1'b0);
        run_single(1, 0, 2, 0, 1'b0);
        run_single(0, 15, 16, 14, 1'b1);

        // Reset in the middle of a run
        @(negedge clk);
        req    = '0;
        req[0] = 1'b1;
        len[0 +: CW] = CW'(10);
        hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(negedge clk);
            if (busy && count == CW'(3)) hit = 1'b1;
        end
        chk("rst_reach", 32'(hit), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_count", 32'(count), 32'd0);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1010;
        @(negedge clk);
        chk("rst_first_grant", 32'(grant), 32'b0010);

        // Randomized traffic: requesters hold req until their done pulse
        for (int it = 0; it < 3000; it++) begin
            @(negedge clk);
            if (it == 1500) begin
                #1 rst_n = 1'b0;
                req = '0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (done[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    len[i*CW +: CW] = CW'($urandom_range(0, (1 << CW) - 1));
                end else if ($urandom_range(0, 15) == 0) begin
                    len[i*CW +: CW] = CW'($urandom_range(0, (1 << CW) - 1));
                end
            end
        end

        req = '0;
        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
